// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam int PC_W = 32;
  localparam int INSTR_W = 32;

  // addi x0,x0,0 : the encoding ID sees whenever IF/ID holds a bubble
  localparam logic [INSTR_W-1:0] NOP_ENC = 32'h0000_0013;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // FETCH: request at PC; HELD: buffered instr waiting out a stall;
  // DRAIN: stale request from before a redirect still in flight
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Sequential PC step; wraps modulo 2^32 with no overflow indication
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: request completes in the cycle ready is high.
// Backpressure: ready low holds the request and its address unchanged.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with write enable and squash-to-bubble.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: write_en low holds contents; squash overrides write_en.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_en,
  input  logic               squash,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  // Bubble on reset or squash, otherwise load when enabled, else hold
  always_ff @(posedge clk) begin
    if (!rst_n || squash) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (write_en) begin
      pc    <= in_pc;
      instr <= in_instr;
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, imem request FSM, one-entry hold buffer feeding IF/ID.
// Latency: PC issued in cycle N with ready high appears on ID in cycle N+1.
// Backpressure: stall parks a completed fetch in the hold buffer; ready low holds the request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               PCWrite_i,
  input  logic               IF_ID_write_i,
  input  logic               Flush_i,
  input  logic [PC_W-1:0]    Branch_target_i,
  fetch_unit_if.master       imem,
  output logic [PC_W-1:0]    ID_PC_o,
  output logic [INSTR_W-1:0] ID_Instruction_o,
  output logic               ID_valid_o
);

  fetch_state_t       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    drain_addr;
  logic [INSTR_W-1:0] hold_buf;

  logic               stall;
  logic               fetch_done;
  logic               avail;
  logic               req_stuck;
  logic [INSTR_W-1:0] instr;
  logic               id_write;
  logic               id_squash;

  // The hazard unit drives both enables together; either low means stall
  assign stall = !PCWrite_i || !IF_ID_write_i;

  // No request while in reset or while the buffer already holds the next instr.
  // DRAIN keeps presenting the pre-redirect address until the memory retires it.
  assign imem.req  = rst_i && (state != HELD);
  assign imem.addr = (state == DRAIN) ? drain_addr : pc;

  assign fetch_done = (state == FETCH) && imem.req && imem.ready;
  assign avail      = fetch_done || (state == HELD);
  assign req_stuck  = imem.req && !imem.ready;
  assign instr      = (state == HELD) ? hold_buf : imem.rdata;

  // Load on a real instruction; bubble on flush or when nothing arrived
  // and ID is free to advance. Under stall with no flush, IF/ID holds.
  assign id_write  = avail && !stall;
  assign id_squash = Flush_i || (!stall && !avail);

  // Fetch FSM, PC and hold buffer; flush outranks stall in every state
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_buf   <= '0;
      drain_addr <= '0;
    end else if (Flush_i) begin
      pc       <= Branch_target_i;
      hold_buf <= '0;
      if (req_stuck) begin
        // Remember whichever address is in flight (old PC, or the
        // original stale address when already draining)
        drain_addr <= imem.addr;
        state      <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (avail) begin
            if (stall) begin
              hold_buf <= instr;
              state    <= HELD;
            end else begin
              pc <= pc_next(pc);
            end
          end
        end
        HELD: begin
          if (!stall) begin
            pc    <= pc_next(pc);
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem.ready) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  fetch_unit_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .write_en (id_write),
    .squash   (id_squash),
    .in_pc    (pc),
    .in_instr (instr),
    .in_valid (1'b1),
    .pc       (ID_PC_o),
    .instr    (ID_Instruction_o),
    .valid    (ID_valid_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a program-order stream model.
// Latency: n/a.
// Backpressure: memory ready driven from the stimulus.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        ifid_write;
  logic        flush;
  logic [31:0] target;
  logic        ready_tb;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory image: every address holds a distinct, non-NOP word
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0033;
  endfunction

  fetch_unit_if imem ();
  assign imem.ready = ready_tb;
  assign imem.rdata = instr_of(imem.addr);

  fetch_unit dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .PCWrite_i        (pc_write),
    .IF_ID_write_i    (ifid_write),
    .Flush_i          (flush),
    .Branch_target_i  (target),
    .imem             (imem),
    .ID_PC_o          (id_pc),
    .ID_Instruction_o (id_instr),
    .ID_valid_o       (id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_stall(input logic s);
    pc_write   = !s;
    ifid_write = !s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    flush    = 1'b0;
    target   = 32'h0;
    ready_tb = 1'b1;
    set_stall(1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic expect_id(input string name, input logic [31:0] pc, input logic v);
    chk({name, "_valid"}, {31'b0, id_valid}, {31'b0, v});
    if (v) begin
      chk({name, "_pc"}, id_pc, pc);
      chk({name, "_instr"}, id_instr, instr_of(pc));
    end
  endtask

  // ---------------- stream model ----------------
  // ID must present the program-order stream: after reset RESET_PC, after
  // a redirect the target, otherwise each new valid instr is previous+4.
  // A stall freezes ID, a flush or reset forces a bubble.
  logic [31:0] exp_next = 32'h0;
  bit          have_prev = 0;
  logic        s_rst, s_stall, s_flush, s_req, s_ready, s_valid;
  logic [31:0] s_target, s_addr, s_pc, s_instr;

  always @(negedge clk) begin
    assert (pc_write == ifid_write);
    if (have_prev) begin
      if (!rst_n) chk("m_req_in_reset", {31'b0, imem.req}, 32'd0);
      if (!s_rst) begin
        chk("m_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("m_rst_pc", id_pc, 32'h0);
        exp_next = RESET_PC_DEF;
      end else if (s_flush) begin
        chk("m_flush_bubble", {31'b0, id_valid}, 32'd0);
        exp_next = s_target;
      end else if (s_stall) begin
        chk("m_hold_valid", {31'b0, id_valid}, {31'b0, s_valid});
        chk("m_hold_pc", id_pc, s_pc);
        chk("m_hold_instr", id_instr, s_instr);
      end else if (id_valid) begin
        chk("m_seq_pc", id_pc, exp_next);
        chk("m_seq_instr", id_instr, instr_of(exp_next));
        exp_next = exp_next + 32'd4;
      end
      if (!id_valid) chk("m_bubble_nop", id_instr, NOP_ENC);
      if (s_rst && rst_n && s_req && !s_ready) begin
        chk("m_req_held", {31'b0, imem.req}, 32'd1);
        chk("m_addr_stable", imem.addr, s_addr);
      end
    end
    s_rst    = rst_n;
    s_stall  = !pc_write || !ifid_write;
    s_flush  = flush;
    s_target = target;
    s_req    = imem.req;
    s_ready  = ready_tb;
    s_addr   = imem.addr;
    s_valid  = id_valid;
    s_pc     = id_pc;
    s_instr  = id_instr;
    have_prev = 1;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    target   = 32'h0;
    ready_tb = 1'b1;
    set_stall(1'b0);
    tick();
    tick();

    // 1: reset state, then straight-line fetch
    chk("t1_req_reset", {31'b0, imem.req}, 32'd0);
    chk("t1_valid_reset", {31'b0, id_valid}, 32'd0);
    chk("t1_instr_reset", id_instr, NOP_ENC);
    chk("t1_pc_reset", id_pc, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("t1_req_release", {31'b0, imem.req}, 32'd1);
    chk("t1_addr_release", imem.addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_id("t1", 32'(i * 4), 1'b1);
    end

    // 2: one-cycle load-use stall while PC=8 -> 4,4,8,12
    do_reset();
    tick();
    tick();
    expect_id("t2_a", 32'h4, 1'b1);
    chk("t2_addr8", imem.addr, 32'h8);
    set_stall(1'b1);
    tick();
    expect_id("t2_b", 32'h4, 1'b1);
    chk("t2_req_held", {31'b0, imem.req}, 32'd0);
    set_stall(1'b0);
    tick();
    expect_id("t2_c", 32'h8, 1'b1);
    tick();
    expect_id("t2_d", 32'hC, 1'b1);

    // 3: memory wait states at PC=16
    do_reset();
    repeat (4) tick();
    expect_id("t3_pre", 32'hC, 1'b1);
    ready_tb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_id("t3_wait", 32'h0, 1'b0);
      chk("t3_addr", imem.addr, 32'h10);
    end
    ready_tb = 1'b1;
    tick();
    expect_id("t3_post", 32'h10, 1'b1);

    // 4: flush and stall in the same cycle
    do_reset();
    tick();
    tick();
    flush  = 1'b1;
    target = 32'h100;
    set_stall(1'b1);
    tick();
    expect_id("t4_bubble", 32'h0, 1'b0);
    chk("t4_addr", imem.addr, 32'h100);
    flush = 1'b0;
    set_stall(1'b0);
    tick();
    expect_id("t4_a", 32'h100, 1'b1);
    tick();
    expect_id("t4_b", 32'h104, 1'b1);

    // 5: flush while the request at 0x20 is still outstanding
    do_reset();
    repeat (8) tick();
    expect_id("t5_pre", 32'h1C, 1'b1);
    ready_tb = 1'b0;
    tick();
    flush  = 1'b1;
    target = 32'h200;
    tick();
    flush = 1'b0;
    chk("t5_drain_addr", imem.addr, 32'h20);
    chk("t5_drain_req", {31'b0, imem.req}, 32'd1);
    repeat (2) tick();
    chk("t5_drain_addr2", imem.addr, 32'h20);
    expect_id("t5_drain_id", 32'h0, 1'b0);
    ready_tb = 1'b1;
    tick();
    chk("t5_redirect", imem.addr, 32'h200);
    expect_id("t5_dropped", 32'h0, 1'b0);
    tick();
    expect_id("t5_target", 32'h200, 1'b1);

    // 6: reset while HELD
    do_reset();
    tick();
    set_stall(1'b1);
    tick();
    chk("t6_held_req", {31'b0, imem.req}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_req", {31'b0, imem.req}, 32'd0);
    expect_id("t6_rst_id", 32'h0, 1'b0);
    set_stall(1'b0);
    rst_n = 1'b1;
    #1;
    chk("t6_addr", imem.addr, 32'h0);
    tick();
    expect_id("t6_refetch", 32'h0, 1'b1);

    // 7: PC wraps past the top of the address space
    do_reset();
    tick();
    flush  = 1'b1;
    target = 32'hFFFF_FFF8;
    tick();
    flush = 1'b0;
    tick();
    expect_id("t7_a", 32'hFFFF_FFF8, 1'b1);
    tick();
    expect_id("t7_b", 32'hFFFF_FFFC, 1'b1);
    tick();
    expect_id("t7_wrap", 32'h0, 1'b1);

    // 8: flush while HELD discards the buffered instruction
    do_reset();
    tick();
    set_stall(1'b1);
    tick();
    flush  = 1'b1;
    target = 32'h40;
    tick();
    expect_id("t8_bubble", 32'h0, 1'b0);
    chk("t8_addr", imem.addr, 32'h40);
    flush = 1'b0;
    set_stall(1'b0);
    tick();
    expect_id("t8_target", 32'h40, 1'b1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
